uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Purpose     : 8N1 UART transmitter (LSB first) fed by a circular byte FIFO.
// Latency     : 1 cycle from the accept edge to the start bit on an idle line.
// Backpressure: tx_ready drops while the FIFO holds FIFO_DEPTH bytes and during reset.
//
// Ports (uart_tx_fifo):
//   fpga_clk   - system clock, all logic on the rising edge
//   fpga_rst   - synchronous active-high reset
//   tx_data    - byte offered by the CPU I/O port
//   tx_valid   - tx_data valid this cycle
//   tx_ready   - FIFO can accept a byte this cycle
//   tx         - serial line to the PC, idle high, registered
//   busy       - FIFO non-empty or a frame in progress
//   fifo_count - bytes queued, excluding the byte being shifted out

// Purpose     : circular byte buffer with wrapping read/write pointers.
// Latency     : a push is visible at head_dat one edge later; head_dat is combinational.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports (uart_tx_fifo_buf):
//   clk, rst           - clock and synchronous active-high reset
//   push, push_dat     - write request and data
//   pop                - advance the read pointer
//   head_dat           - oldest stored entry
//   count              - number of stored entries (0..DEPTH)
module uart_tx_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged on the registered count only, so a pop in the same
    // cycle never lets a full buffer take another entry.
    assign do_push  = push && !rst && (count != CNT_FULL);
    assign do_pop   = pop  && !rst && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             fpga_clk,
    input  logic             fpga_rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        head_dat;
    logic              baud_done;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign fifo_empty = (fifo_count == '0);

    assign tx_ready = !fpga_rst && (fifo_count != CNT_FULL);
    assign push     = tx_valid && tx_ready;

    // The head byte is taken either from an idle line or on the last cycle of
    // a stop bit, which chains frames with no idle gap between them.
    assign pop = !fpga_rst && !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && baud_done));

    assign busy = (state != IDLE) || !fifo_empty;

    uart_tx_fifo_buf #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk      (fpga_clk),
        .rst      (fpga_rst),
        .push     (push),
        .push_dat (tx_data),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    // Bit timing: baud_cnt runs 0..CLKS_PER_BIT-1 within each bit; the line
    // value for the next bit is registered on the edge that ends the current
    // one, so tx only ever changes on a clock edge.
    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state     <= START;
                        shift_reg <= head_dat;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        tx        <= 1'b0;
                    end
                end

                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // shift_reg[1] becomes shift_reg[0] after the shift,
                            // so drive it now to keep tx aligned with the counter.
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state     <= START;
                            shift_reg <= head_dat;
                            bit_idx   <= '0;
                            tx        <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose     : self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Latency     : checks the 1-cycle accept-to-start-bit latency and 40-cycle frames.
// Backpressure: drives tx_valid and holds it until the reference model accepts.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int FRAME = 10 * CPB;

    logic             fpga_clk;
    logic             fpga_rst;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] dat;
        logic [9:0] frame;   // line value per bit slot: [0]=start, [8:1]=data, [9]=stop
    } vec_t;
    vec_t vecs[5];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CNT_W)
    ) dut (
        .fpga_clk   (fpga_clk),
        .fpga_rst   (fpga_rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting bytes plus the position inside the
    // frame currently on the line (-1 when the line is idle).
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] cur;
    int         pos = -1;
    int         cyc = 0;
    bit         chk_en = 1'b0;
    bit         last_accept = 1'b0;

    always @(posedge fpga_clk) begin : model_blk
        bit rdy;
        bit acc;
        cyc++;
        rdy = !fpga_rst && (mq.size() != DEPTH);
        acc = tx_valid && rdy;
        last_accept = acc;
        if (fpga_rst) begin
            mq.delete();
            pos    = -1;
            chk_en = 1'b1;
        end else begin
            if (mq.size() != 0 && (pos < 0 || pos == FRAME - 1)) begin
                cur = mq.pop_front();
                pos = 0;
            end else if (pos >= 0) begin
                pos++;
                if (pos == FRAME) pos = -1;
            end
            if (acc) begin
                mq.push_back(tx_data);
                sent_q.push_back(tx_data);
            end
        end
    end

    function automatic logic model_tx();
        int idx;
        if (pos < 0) return 1'b1;
        idx = pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return cur[3'(idx - 1)];
    endfunction

    always @(negedge fpga_clk) begin
        if (chk_en) begin
            check("mdl_tx",       32'(tx),         32'(model_tx()));
            check("mdl_count",    32'(fifo_count), 32'(mq.size()));
            check("mdl_busy",     32'(busy),       32'(pos >= 0 || mq.size() != 0));
            check("mdl_tx_ready", 32'(tx_ready),   32'(!fpga_rst && mq.size() != DEPTH));
        end
    end

    // Line monitor: decodes frames by sampling the middle of each bit slot.
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         nstarts = 0;
    int         off = 0;
    bit         in_frame = 1'b0;
    logic [7:0] rx_sh;
    logic       prev_tx = 1'b1;

    always @(negedge fpga_clk) begin : mon_blk
        int k;
        if (!chk_en || fpga_rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                in_frame = 1'b1;
                off      = 0;
                nstarts++;
                start_q.push_back(cyc);
            end
        end else begin
            off++;
            if (off % CPB == CPB / 2) begin
                k = off / CPB;
                if (k == 0) begin
                    check("mon_start_bit", 32'(tx), 0);
                end else if (k <= 8) begin
                    rx_sh = {tx, rx_sh[7:1]};
                end else begin
                    check("mon_stop_bit", 32'(tx), 1);
                    rx_q.push_back(rx_sh);
                end
            end
            if (off == FRAME - 1) in_frame = 1'b0;
        end
        prev_tx = tx;
    end

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n;
        n        = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 500);
        tx_valid = 1'b0;
        check("push_handshake", 32'(last_accept), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pos >= 0 || mq.size() != 0) && n < 4000) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 4000), 1);
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int e0;
        int ns;
        logic [7:0] exp4[4];

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        fpga_rst = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx",       32'(tx),         1);
            check("rst_busy",     32'(busy),       0);
            check("rst_count",    32'(fifo_count), 0);
            check("rst_tx_ready", 32'(tx_ready),   0);
        end
        fpga_rst = 1'b0;
        #1;
        check("tx_ready_after_rst", 32'(tx_ready), 1);

        // Single frames against hand-written line patterns.
        for (int k = 0; k < 5; k++) begin
            wait_idle();
            rx_q.delete();
            tx_data  = vecs[k].dat;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            check("tbl_accept",    32'(last_accept), 1);
            check("tbl_count_e0",  32'(fifo_count),  1);
            check("tbl_idle_e0",   32'(tx),          1);
            tick();
            check("tbl_start_lat", 32'(tx),          0);
            check("tbl_count_e1",  32'(fifo_count),  0);
            for (int c = 0; c < FRAME; c++) begin
                check("tbl_bit",  32'(tx),   32'(vecs[k].frame[4'(c / CPB)]));
                check("tbl_busy", 32'(busy), 1);
                tick();
            end
            check("tbl_busy_end", 32'(busy), 0);
            check("tbl_rx_size",  32'(rx_q.size()), 1);
            if (rx_q.size() != 0) check("tbl_rx_byte", 32'(rx_q[0]), 32'(vecs[k].dat));
        end

        // Burst into a full FIFO.
        wait_idle();
        rx_q.delete();
        start_q.delete();
        push_byte(8'h01);
        e0 = cyc;
        for (int b = 2; b <= 5; b++) push_byte(8'(b));
        check("burst_consecutive", 32'(cyc - e0), 4);
        check("burst_full_count",  32'(fifo_count), 4);
        check("burst_full_ready",  32'(tx_ready), 0);
        push_byte(8'h06);
        check("burst_06_accept_cycle", 32'(cyc - e0), 42);
        wait_idle();
        check("burst_rx_size", 32'(rx_q.size()), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check("burst_rx_byte", 32'(rx_q[i]), 32'(i + 1));
        for (int i = 1; i < 6 && i < start_q.size(); i++)
            check("burst_start_spacing", 32'(start_q[i] - start_q[i-1]), FRAME);

        // Push on the exact edge that ends a frame (pop and push together).
        wait_idle();
        rx_q.delete();
        exp4 = '{8'h3A, 8'hC5, 8'h7E, 8'h96};
        push_byte(exp4[0]);
        e0 = cyc;
        push_byte(exp4[1]);
        push_byte(exp4[2]);
        check("simul_pre_count", 32'(fifo_count), 2);
        while (cyc < e0 + FRAME) tick();
        tx_data  = exp4[3];
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("simul_accept", 32'(last_accept), 1);
        check("simul_count",  32'(fifo_count),  2);
        check("simul_start",  32'(tx),          0);
        wait_idle();
        check("simul_rx_size", 32'(rx_q.size()), 4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++)
            check("simul_rx_byte", 32'(rx_q[i]), 32'(exp4[i]));

        // Random bytes with random gaps; pointers wrap several times.
        wait_idle();
        rx_q.delete();
        sent_q.delete();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(20, 80)) tick();
            push_byte(8'($urandom_range(0, 255)));
        end
        wait_idle();
        check("rand_sent_size", 32'(sent_q.size()), 20);
        check("rand_rx_size",   32'(rx_q.size()),   32'(sent_q.size()));
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            check("rand_rx_byte", 32'(rx_q[i]), 32'(sent_q[i]));

        // Reset during data bit 3 with two bytes queued.
        wait_idle();
        rx_q.delete();
        push_byte(8'h52);
        e0 = cyc;
        push_byte(8'h11);
        push_byte(8'h22);
        while (cyc < e0 + 1 + 17) tick();
        check("mid_pre_count", 32'(fifo_count), 2);
        check("mid_bit3",      32'(tx),         0);
        fpga_rst = 1'b1;
        tick();
        check("mid_rst_tx",       32'(tx),         1);
        check("mid_rst_count",    32'(fifo_count), 0);
        check("mid_rst_busy",     32'(busy),       0);
        check("mid_rst_tx_ready", 32'(tx_ready),   0);
        fpga_rst = 1'b0;
        ns = nstarts;
        repeat (100) tick();
        check("mid_no_restart", 32'(nstarts),     32'(ns));
        check("mid_no_decode",  32'(rx_q.size()), 0);
        check("mid_line_idle",  32'(tx),          1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
